// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-ported register file with a self-sweeping clear.
// After reset (or a clear request) the array is zeroed one entry per cycle;
// only once every entry has been swept does the file report ready and
// accept writes. Reads are combinational, with same-cycle write bypass.
//
// Handshake: ready_o is a level, not a pulse. A write on port k is accepted
// on a rising edge exactly when ready_o=1, clear_i=0 and wr_en_i[k]=1; there
// is no back-pressure beyond ready_o, and writes presented while ready_o=0
// are silently ignored.
//
// The FSM state is held in state_q (type state_e) so checkers can bind to it.

module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic [NUM_WR-1:0]      wr_en_i,
    input  logic [NUM_WR*AW-1:0]   rd_addr_i,
    input  logic [NUM_WR*XLEN-1:0] wr_data_i,
    input  logic [NUM_RD*AW-1:0]   rs_addr_i,
    output logic [NUM_RD*XLEN-1:0] rs_data_o,
    output logic                   ready_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e            state_q;
    logic   [AW-1:0]   cnt_q;
    logic              ready_q;
    logic   [XLEN-1:0] mem_q [DEPTH];

    // Unpacked views of the packed port buses.
    logic [AW-1:0]   wr_addr [NUM_WR];
    logic [XLEN-1:0] wr_data [NUM_WR];
    logic [AW-1:0]   rs_addr [NUM_RD];
    // A write is "kept" when enabled and not aimed at a hardwired zero register.
    logic [NUM_WR-1:0] wr_keep;

    genvar gk, gj;
    generate
        for (gk = 0; gk < NUM_WR; gk++) begin : g_wr_unpack
            assign wr_addr[gk] = rd_addr_i[gk*AW +: AW];
            assign wr_data[gk] = wr_data_i[gk*XLEN +: XLEN];
            assign wr_keep[gk] = wr_en_i[gk] &&
                                 !((ZERO_REG != 0) && (wr_addr[gk] == '0));
        end
        for (gj = 0; gj < NUM_RD; gj++) begin : g_rd_unpack
            assign rs_addr[gj] = rs_addr_i[gj*AW +: AW];
        end
    endgenerate

    // Control FSM: sweep counter in CLEAR, clear requests in READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    // clear_i is deliberately ignored here: the sweep runs to completion.
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                ST_READY: begin
                    if (clear_i) begin
                        state_q <= ST_CLEAR;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;

    // Array update: sweep zeroing in CLEAR, port writes in READY (later port wins).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else if (!clear_i) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (wr_keep[k]) begin
                        mem_q[wr_addr[k]] <= wr_data[k];
                    end
                end
            end
        end
    end

    // Combinational read lanes with write bypass; lanes are zero while sweeping.
    always_comb begin
        rs_data_o = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            logic [XLEN-1:0] lane;
            lane = mem_q[rs_addr[j]];
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_keep[k] && (wr_addr[k] == rs_addr[j])) begin
                    lane = wr_data[k];
                end
            end
            if ((ZERO_REG != 0) && (rs_addr[j] == '0)) begin
                lane = '0;
            end
            if (state_q != ST_READY) begin
                lane = '0;
            end
            rs_data_o[j*XLEN +: XLEN] = lane;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized and directed checks of reg_file_mp against a
// behavioural model (array + remaining-sweep-cycles count). A second
// instance covers a small, unequal-port configuration.

module tb_reg_file_mp;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (defaults) ----------------
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [1:0]  we = 2'b00;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [4:0]  ra [2];
    logic [9:0]  rd_addr_bus;
    logic [63:0] wr_data_bus;
    logic [9:0]  rs_addr_bus;
    logic [63:0] rs_data;
    logic        ready;

    assign rd_addr_bus = {wa[1], wa[0]};
    assign wr_data_bus = {wd[1], wd[0]};
    assign rs_addr_bus = {ra[1], ra[0]};

    reg_file_mp dut (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear),
        .wr_en_i   (we),
        .rd_addr_i (rd_addr_bus),
        .wr_data_i (wr_data_bus),
        .rs_addr_i (rs_addr_bus),
        .rs_data_o (rs_data),
        .ready_o   (ready)
    );

    // ---------------- small DUT: DEPTH=8, 3 read, 1 write ----------------
    logic        s_rst = 1'b1;
    logic        s_we = 1'b0;
    logic [2:0]  s_wa = 3'd0;
    logic [31:0] s_wd = 32'd0;
    logic [8:0]  s_ra = 9'd0;
    logic [95:0] s_rd;
    logic        s_ready;

    reg_file_mp #(.XLEN(32), .DEPTH(8), .NUM_RD(3), .NUM_WR(1), .ZERO_REG(1)) dut_s (
        .clk       (clk),
        .rst       (s_rst),
        .clear_i   (1'b0),
        .wr_en_i   (s_we),
        .rd_addr_i (s_wa),
        .wr_data_i (s_wd),
        .rs_addr_i (s_ra),
        .rs_data_o (s_rd),
        .ready_o   (s_ready)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [32];
    bit          m_ready = 1'b0;
    int          m_left  = 32;
    logic [31:0] exp_q [$];

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        if (rst) begin
            m_ready = 1'b0;
            m_left  = 32;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int a = 0; a < 32; a++) m_mem[a] = 32'd0;
            end
        end else if (clear) begin
            m_ready = 1'b0;
            m_left  = 32;
        end else begin
            for (int k = 0; k < 2; k++)
                if (we[k] && wa[k] != 5'd0) m_mem[wa[k]] = wd[k];
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [31:0] r;
        if (!m_ready || a == 5'd0) return 32'd0;
        r = m_mem[a];
        for (int k = 0; k < 2; k++)
            if (we[k] && wa[k] == a) r = wd[k];
        return r;
    endfunction

    // Check outputs mid-cycle (optionally), then take one edge and update the model.
    task automatic cycle(input bit do_chk);
        #3;
        if (do_chk) begin
            chk("ready", {63'd0, ready}, {63'd0, m_ready});
            for (int j = 0; j < 2; j++) exp_q.push_back(exp_read(ra[j]));
            for (int j = 0; j < 2; j++) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk($sformatf("rd%0d@x%0d", j, ra[j]), {32'd0, rs_data[j*32 +: 32]}, {32'd0, e});
            end
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we = 2'b00; clear = 1'b0;
    endtask

    // Count edges until ready_o rises, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            cycle(1'b1);
            n++;
        end
    endtask

    int n;

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < 2; k++) begin wa[k] = '0; wd[k] = '0; ra[k] = '0; end
        for (int a = 0; a < 32; a++) m_mem[a] = 32'd0;

        // reset and first sweep
        rst = 1'b1;
        cycle(1'b0);
        cycle(1'b1);
        chk("reset_ready", {63'd0, ready}, 64'd0);
        rst = 1'b0;
        wait_ready(n);
        chk("sweep_len", n, 32);
        for (int a = 0; a < 32; a += 2) begin
            ra[0] = a[4:0]; ra[1] = 5'(a + 1);
            cycle(1'b1);
        end

        // two ports write x5 in the same cycle: port 1 wins
        we = 2'b11; wa[0] = 5'd5; wa[1] = 5'd5;
        wd[0] = 32'hDEADBEEF; wd[1] = 32'h12345678;
        ra[0] = 5'd5; ra[1] = 5'd5;
        #2 chk("x5_bypass", {32'd0, rs_data[31:0]}, 64'h12345678);
        cycle(1'b1);
        idle_inputs();
        #2 chk("x5_next", {32'd0, rs_data[63:32]}, 64'h12345678);
        cycle(1'b1);

        // write to x0 is dropped
        we = 2'b01; wa[0] = 5'd0; wd[0] = 32'hFFFFFFFF; ra[0] = 5'd0; ra[1] = 5'd0;
        #2 chk("x0_same", rs_data, 64'd0);
        cycle(1'b1);
        idle_inputs();
        #2 chk("x0_next", rs_data, 64'd0);
        cycle(1'b1);

        // fill x1..x31 with own index
        for (int a = 1; a < 32; a += 2) begin
            we = (a == 31) ? 2'b01 : 2'b11;
            wa[0] = a[4:0]; wd[0] = a;
            wa[1] = 5'(a + 1); wd[1] = a + 1;
            cycle(1'b1);
        end
        idle_inputs();
        for (int a = 0; a < 32; a += 2) begin
            ra[0] = a[4:0]; ra[1] = 5'(a + 1);
            cycle(1'b1);
        end

        // clear alongside a write x7=0xAA
        clear = 1'b1; we = 2'b01; wa[0] = 5'd7; wd[0] = 32'hAA;
        cycle(1'b1);
        idle_inputs();
        wait_ready(n);
        chk("clear_len", n, 32);
        ra[0] = 5'd7; ra[1] = 5'd7;
        #2 chk("x7_cleared", {32'd0, rs_data[31:0]}, 64'd0);
        for (int a = 0; a < 32; a += 2) begin
            ra[0] = a[4:0]; ra[1] = 5'(a + 1);
            cycle(1'b1);
        end

        // reset mid-sweep at cnt=10 restarts the sweep
        clear = 1'b1;
        cycle(1'b1);
        clear = 1'b0;
        repeat (10) cycle(1'b1);
        rst = 1'b1;
        cycle(1'b1);
        rst = 1'b0;
        wait_ready(n);
        chk("rst_midsweep_len", n, 32);

        // randomized traffic with occasional clear and reset
        for (int i = 0; i < 400; i++) begin
            we    = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                wa[k] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                wd[k] = $urandom;
            end
            for (int j = 0; j < 2; j++)
                ra[j] = ($urandom_range(0, 2) == 0) ? wa[$urandom_range(0, 1)] : 5'($urandom_range(0, 7));
            clear = ($urandom_range(0, 99) == 0);
            rst   = ($urandom_range(0, 149) == 0);
            cycle(1'b1);
        end
        rst = 1'b0; idle_inputs();
        wait_ready(n);
        chk("final_ready", {63'd0, ready}, 64'd1);

        // small instance: sweep length and triple read of x3
        s_rst = 1'b1;
        @(posedge clk); #1;
        s_rst = 1'b0;
        n = 0;
        while (!s_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("s_sweep_len", n, 8);
        s_we = 1'b1; s_wa = 3'd3; s_wd = 32'h55; s_ra = {3'd3, 3'd3, 3'd3};
        #2;
        for (int j = 0; j < 3; j++) chk($sformatf("s_byp%0d", j), {32'd0, s_rd[j*32 +: 32]}, 64'h55);
        @(posedge clk); #1;
        s_we = 1'b0;
        #2;
        for (int j = 0; j < 3; j++) chk($sformatf("s_rd%0d", j), {32'd0, s_rd[j*32 +: 32]}, 64'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
